z_flag_reg: RTL and testbench

- Zero-flag register for the processor datapath.
- On a write strobe it samples a WIDTH-bit result word, evaluates "word equals zero" and stores that single bit as the Z flag.
- The registered flag feeds the control unit for conditional branches.
- Pure flag storage: no arithmetic beyond the zero test.

---
 rtl/z_flag_reg_pkg.sv | 13 +
 rtl/z_flag_reg_if.sv | 25 ++
 rtl/z_flag_reg.sv | 43 ++++
 tb/tb_z_flag_reg.sv | 121 ++++++++++++
 4 files changed

// File: rtl/z_flag_reg_pkg.sv
// Shared processor constants: the datapath word width that the ALU, the register
// file and the flag registers all agree on.
package z_flag_reg_pkg;

    localparam int unsigned DataWidth = 12;
    localparam int unsigned MinWidth  = 1;
    localparam int unsigned MaxWidth  = 64;

    function automatic bit widthLegal(input int unsigned w);
        return (w >= MinWidth) && (w <= MaxWidth);
    endfunction

endpackage

// File: rtl/z_flag_reg_if.sv
// Result-word and flag signals between the datapath (master) and the Z flag
// register (slave).
interface z_flag_reg_if
    import z_flag_reg_pkg::*;
#(
    parameter int unsigned WIDTH = DataWidth
);

    logic [WIDTH-1:0] dataIn;
    logic             wrEn;
    logic             Zout;

    modport master (
        output dataIn,
        output wrEn,
        input  Zout
    );

    modport slave (
        input  dataIn,
        input  wrEn,
        output Zout
    );

endinterface

// File: rtl/z_flag_reg.sv
// Zero-flag register: on a write strobe, stores whether the result word is all zeros.
// Zout comes straight from the flop, so the control unit sees no input-to-output path.
module z_flag_reg
    import z_flag_reg_pkg::*;
#(
    parameter int unsigned WIDTH = DataWidth
) (
    input  logic        clk,
    input  logic        rst,
    z_flag_reg_if.slave bus
);

    localparam bit WidthOk = widthLegal(WIDTH);

    logic zD;
    logic zQ;

    // Only the all-zeros pattern counts; no sign interpretation.
    assign zD = ~|bus.dataIn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zQ <= 1'b0;
        end else if (bus.wrEn) begin
            zQ <= zD;
        end
    end

    assign bus.Zout = zQ;

    // An unknown word must not be silently folded into a clean flag value.
    knownInputs: assert property (@(posedge clk) disable iff (rst)
        !$isunknown({bus.wrEn, bus.dataIn}));

    resetClears: assert property (@(posedge clk) rst |-> !bus.Zout);

    holdWhenIdle: assert property (@(posedge clk) disable iff (rst)
        !bus.wrEn |=> $stable(bus.Zout));

    widthChecked: assert property (@(posedge clk)
        WidthOk && ($bits(bus.dataIn) == int'(WIDTH)));

endmodule

// File: tb/tb_z_flag_reg.sv
// Self-checking bench for z_flag_reg: directed cases followed by a randomized run
// scored against a cycle-level model of the flag.
module tb_z_flag_reg;

    localparam int unsigned W = 12;

    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    logic expZ;
    logic prevRst;

    z_flag_reg_if #(.WIDTH(W)) bus ();

    z_flag_reg #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed Zout=%b expected=%b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle's inputs just after an edge, check any asynchronous clear,
    // then advance through the next rising edge and score the flag.
    task automatic step(input string tag, input logic r, input logic w, input logic [W-1:0] d);
        rst        = r;
        bus.wrEn   = w;
        bus.dataIn = d;
        if (r && !prevRst) begin
            #1;
            check({tag, "_asyncClr"}, bus.Zout, 1'b0);
        end
        prevRst = r;
        @(posedge clk);
        if (r)       expZ = 1'b0;
        else if (w)  expZ = (d == '0);
        #1;
        check(tag, bus.Zout, expZ);
    endtask

    initial begin
        logic [W-1:0] seqData [5];
        logic         seqZ    [5];
        logic [W-1:0] rd;
        logic         rr;
        logic         rw;

        rst        = 1'b0;
        bus.wrEn   = 1'b0;
        bus.dataIn = '0;
        prevRst    = 1'b0;
        expZ       = 1'b0;

        // Reset pulse entirely between clock edges.
        #2 rst = 1'b1;
        #1 check("resetPulse", bus.Zout, 1'b0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("resetHold0", bus.Zout, 1'b0);
        step("resetHold1", 1'b0, 1'b0, '0);
        step("resetHold2", 1'b0, 1'b0, '0);

        // Zero write, then hold with a nonzero word on the bus.
        step("zeroWrite", 1'b0, 1'b1, 12'h000);
        check("zeroWriteConst", bus.Zout, 1'b1);
        for (int i = 0; i < 4; i++) step("holdOne", 1'b0, 1'b0, 12'h005);
        check("holdOneConst", bus.Zout, 1'b1);

        // Nonzero writes including MSB-only and all-ones.
        step("nonzero4", 1'b0, 1'b1, 12'h004);
        check("nonzero4Const", bus.Zout, 1'b0);
        step("zeroAgain", 1'b0, 1'b1, 12'h000);
        step("msbOnly", 1'b0, 1'b1, 12'h800);
        check("msbOnlyConst", bus.Zout, 1'b0);
        step("zeroAgain2", 1'b0, 1'b1, 12'h000);
        step("allOnes", 1'b0, 1'b1, 12'hFFF);
        check("allOnesConst", bus.Zout, 1'b0);

        // Back-to-back writes on consecutive edges.
        seqData = '{12'h000, 12'h001, 12'h000, 12'h000, 12'h007};
        seqZ    = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            step("backToBack", 1'b0, 1'b1, seqData[i]);
            check("backToBackTable", bus.Zout, seqZ[i]);
        end

        // Reset wins over a same-cycle zero write; the write lands once released.
        step("rstPriority", 1'b1, 1'b1, 12'h000);
        check("rstPriorityConst", bus.Zout, 1'b0);
        step("afterRst", 1'b0, 1'b1, 12'h000);
        check("afterRstConst", bus.Zout, 1'b1);

        // Randomized run.
        for (int i = 0; i < 200; i++) begin
            rr = ($urandom_range(0, 9) == 0);
            rw = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 3) == 0) rd = '0;
            else                           rd = W'($urandom());
            step("random", rr, rw, rd);
        end

        rst      = 1'b0;
        bus.wrEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
